// File: rtl/bus_terminal_rx.sv
// Receive endpoint for one tec_riscv_bus terminal: drains the bus queue, filters on
// terminal address and buffers accepted messages in a fall-through FIFO.
module bus_terminal_rx #(
    parameter logic [2:0] TERM_ID = 3'd0,
    parameter int         DEPTH   = 4,
    parameter int         CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pndng,
    input  logic [64:0]              D_pop,
    output logic                     pop,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [1:0]               rx_src,
    output logic                     rx_bcst,
    output logic [59:0]              rx_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int         AW      = $clog2(DEPTH);
    localparam int         CW      = AW + 1;
    localparam int         EW      = 63;
    localparam logic [2:0] BCST_ID = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                pop_r;
    logic                pop_s;
    logic                cap_load_s;
    logic [64:0]         cap_r;

    logic [EW-1:0]       mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [CNT_W-1:0]    drop_r;

    logic [2:0]          cap_tgt_s;
    logic                cap_bcst_s;
    logic                accept_s;
    logic                in_drain_s;
    logic                full_s;
    logic                deq_s;
    logic                push_s;
    logic                drop_s;
    logic [EW-1:0]       head_s;

    // Classification of the captured packet and FIFO handshake qualifiers
    assign cap_tgt_s  = cap_r[64:62];
    assign cap_bcst_s = (cap_tgt_s == BCST_ID);
    assign accept_s   = cap_bcst_s || (cap_tgt_s == TERM_ID);
    assign in_drain_s = (state_r == ST_DRAIN);
    assign full_s     = (count_r == CW'(DEPTH));
    assign deq_s      = rx_ready && (count_r != {CW{1'b0}});
    assign push_s     = in_drain_s && accept_s && (!full_s || deq_s);
    assign drop_s     = in_drain_s && !accept_s;

    // Next-state logic: space is judged on the registered count only
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        cap_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pndng && (count_r < CW'(DEPTH))) begin
                    state_s    = ST_DRAIN;
                    pop_s      = 1'b1;
                    cap_load_s = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_DRAIN: state_s = ST_GAP;
            ST_GAP:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM state, packet capture and the registered pop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pop_r   <= 1'b0;
            cap_r   <= {65{1'b0}};
        end else begin
            state_r <= state_s;
            pop_r   <= pop_s;
            if (cap_load_s) begin
                cap_r <= D_pop;
            end
        end
    end

    // FIFO storage and write pointer; storage is cleared so the head never reads X
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {cap_bcst_s, cap_r[61:60], cap_r[59:0]};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
    end

    // Read pointer and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of misaddressed packets
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r <= {CNT_W{1'b0}};
        end else if (drop_s && (drop_r != {CNT_W{1'b1}})) begin
            drop_r <= drop_r + CNT_W'(1);
        end
    end

    assign head_s     = mem_r[rd_ptr_r];
    assign pop        = pop_r;
    assign rx_valid   = (count_r != {CW{1'b0}});
    assign rx_bcst    = head_s[62];
    assign rx_src     = head_s[61:60];
    assign rx_data    = head_s[59:0];
    assign fifo_count = count_r;
    assign drop_cnt   = drop_r;

endmodule

// File: doc/bus_terminal_rx.md
Name: bus_terminal_rx

Overview:
- Peripheral-side receive endpoint for one terminal of tec_riscv_bus.
- Drains the bus's per-terminal output queue through the pndng / D_pop / pop handshake.
- Decodes the 65-bit packet header and filters on terminal address (own ID or broadcast).
- Buffers accepted messages in a small FIFO and presents them to the peripheral on a valid/ready interface; misaddressed packets are dropped and counted.

Parameters:
- TERM_ID, 3'd0, this terminal's 3-bit bus address.
- DEPTH, 4, receive FIFO depth in entries; must be a power of two, range 2..16.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pndng  input  1  bus has a message for this terminal; D_pop is valid while high.
- D_pop  input  65  head packet: [64:62] target, [61:60] source, [59:0] payload.
- pop  output  1  registered one-cycle pulse that dequeues the bus head.
- rx_valid  output  1  FIFO head available to the peripheral.
- rx_ready  input  1  peripheral accepts the head when rx_valid && rx_ready.
- rx_src  output  2  source field of the head entry.
- rx_bcst  output  1  head entry arrived with target 3'b111.
- rx_data  output  60  payload of the head entry.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  CNT_W  saturating count of misaddressed packets.

Behaviour:
- Reset (synchronous, active-high): pop=0, rx_valid=0, rx_src=0, rx_bcst=0, rx_data=0, fifo_count=0, drop_cnt=0, FSM=IDLE.
- Reset mid-operation: FIFO contents discarded and any pending pop pulse cancelled on the reset edge.
- Bus contract: D_pop is stable while pndng=1. A one-cycle pop removes the head. pndng and D_pop reflect the next entry no earlier than the cycle after pop.
- FSM IDLE: if pndng=1 and fifo_count<DEPTH, then:
  - sample D_pop into a capture register;
  - assert pop for exactly the next cycle;
  - go to DRAIN.
  - Otherwise stay in IDLE with pop=0.
- The full check uses fifo_count as registered at the start of the cycle. A dequeue in the same cycle does not free space for that decision.
- FSM DRAIN (one cycle): pop=1 and the capture register is classified.
  - Accept if target==TERM_ID or target==3'b111: push {bcst, source, payload} into the FIFO.
  - Otherwise drop: drop_cnt increments by 1 and saturates at all-ones (no wrap).
  - Next state is always GAP.
- FSM GAP (one cycle): pop=0, wait for the bus to update pndng/D_pop, then return to IDLE.
- Throughput: at most one packet per 3 cycles. Latency is 2 cycles from a pndng sample in IDLE to rx_valid rising on an empty FIFO.
- Backpressure: the FIFO is never overrun. When full, the block stops popping and the packet stays in the bus queue.
- FIFO:
  - First-word fall-through: rx_* outputs show the head combinationally from registered storage; rx_valid = (fifo_count!=0).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop (including when full with a pop, or when count=1): count unchanged, both complete.
  - Pop on empty is ignored.
- rx_src, rx_bcst and rx_data are don't-care when rx_valid=0, but they must not be X after reset.
- A dropped packet never affects the FIFO. An accepted broadcast never affects drop_cnt.

Test Plan:
- Directed accept: TERM_ID=3'd2, present D_pop={3'd2,2'd1,60'h0ABC} with pndng=1 and rx_ready=1.
  - pop pulses exactly one cycle.
  - 2 cycles later: rx_valid=1, rx_src=1, rx_data=60'h0ABC, rx_bcst=0.
  - drop_cnt=0.
- Broadcast and misaddressed: send target 3'b111, then target 3'd5.
  - First packet delivered with rx_bcst=1.
  - Second packet: pop still pulses, FIFO untouched, drop_cnt=1.
- Full backpressure: DEPTH=4, rx_ready=0, 6 queued addressed packets.
  - Exactly 4 pops issued, fifo_count=4, pop held 0 while pndng=1.
  - Then rx_ready=1 for one cycle: fifo_count drops to 3, and the next pop issues within 1 cycle of IDLE re-entry.
- Simultaneous push/pop: rx_ready=1 continuously with back-to-back packets.
  - fifo_count never exceeds 1.
  - Payloads arrive in order 0,1,2,3, one every 3 cycles.
- Drop saturation: CNT_W=2, send 5 misaddressed packets.
  - drop_cnt goes 1,2,3,3,3.
- Reset mid-operation: assert reset in the DRAIN cycle with 2 entries in the FIFO.
  - Next cycle: pop=0, fifo_count=0, rx_valid=0, drop_cnt=0, FSM in IDLE.
  - The captured packet is not pushed.
